// File: rtl/mask_builder_pkg.sv
// Shared types and default sizing for mask_builder and its decoder.
package mask_builder_pkg;

  localparam int IDX_W_DEF  = 4;
  localparam int MASK_W_DEF = 1 << IDX_W_DEF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/mask_dec.sv
// Binary index to one-hot decoder, purely combinational (zero latency, no flow control).
module mask_dec #(
  parameter int IDX_W  = 4,
  parameter int MASK_W = 1 << IDX_W
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [MASK_W-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/mask_builder.sv
// Collects index beats into a one-hot-OR mask; mask_valid rises 1 cycle after the last beat.
// Mask is held under backpressure, idx_ready drops while holding (one bubble per frame); MASK_BUILDER_COUNT_EN adds mask_count.
module mask_builder
  import mask_builder_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    idx_valid,
  output logic                    idx_ready,
  input  logic [IDX_W-1:0]        idx_data,
  input  logic                    idx_last,
  output logic                    mask_valid,
  input  logic                    mask_ready,
  output logic [(1 << IDX_W)-1:0] mask_data,
  output logic                    mask_dup
`ifdef MASK_BUILDER_COUNT_EN
  ,
  output logic [IDX_W:0]          mask_count
`endif
);

  localparam int MASK_W = 1 << IDX_W;

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   acc_q, acc_d;
  logic                dup_q, dup_d;
  logic [MASK_W-1:0]   beat_onehot;

  mask_dec #(
    .IDX_W  (IDX_W),
    .MASK_W (MASK_W)
  ) u_dec (
    .idx_i    (idx_data),
    .onehot_o (beat_onehot)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dup_d   = dup_q;
    case (state_q)
      COLLECT: begin
        if (idx_valid) begin
          acc_d = acc_q | beat_onehot;
          if ((acc_q & beat_onehot) != '0) dup_d = 1'b1;
          if (idx_last) state_d = HOLD;
        end
      end
      HOLD: begin
        // Clearing here means the next frame starts empty once COLLECT is re-entered.
        if (mask_ready) begin
          acc_d   = '0;
          dup_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dup_q   <= dup_d;
    end
  end

  assign idx_ready  = (state_q == COLLECT);
  assign mask_valid = (state_q == HOLD);
  assign mask_data  = acc_q;
  assign mask_dup   = dup_q;

`ifdef MASK_BUILDER_COUNT_EN
  logic [IDX_W:0] count_q, count_d;

  // Counted from the next-state accumulator so the count lands in the same cycle as the mask.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < MASK_W; i++) begin
      count_d = count_d + (IDX_W+1)'(acc_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign mask_count = count_q;
`endif

endmodule
